// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader's byte stream, memory write port and status lines.
//   slave  modport : loader side (consumes start/byte stream, drives writes and status)
//   master modport : host side (byte source / instruction memory / CPU control)
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_stall;
  logic        done;
  logic        error;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_stall, done, error
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_stall, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Parses a 16-bit little-endian word count N, assembles N little-endian 32-bit words from the
// byte stream and writes one word per WRITE cycle. Holds the CPU in stall while not idle.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - imem_loader_if.slave: start, byte_valid/byte_data/byte_ready stream,
//          wr_en/wr_addr/wr_data memory write port, cpu_stall, done, error
// All outputs are registered; none depends combinationally on byte_valid.
module imem_loader #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StChk, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              lane_q;
  logic [31:0]             word_q;
  logic                    byte_ready_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [31:0]             wr_data_q;
  logic                    cpu_stall_q;
  logic                    done_q;
  logic                    error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              chk_q;
`endif

  logic        accept;
  logic [15:0] hdr_len;
  logic        len_bad;
  logic        last_word;
  logic [31:0] word_next;

  assign accept    = bus.byte_valid & byte_ready_q;
  assign hdr_len   = {bus.byte_data, len_q[7:0]};
  assign len_bad   = (hdr_len == 16'd0) || (32'(hdr_len) > DEPTH);
  assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);
  // Bytes enter at the top and shift down, so the first byte ends up in lane 0.
  assign word_next = {bus.byte_data, word_q[31:8]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StLenLo;
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: if (accept) state_d = len_bad ? StIdle : StData;
      StData:  if (accept && lane_q == 2'd3) state_d = StWrite;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StWrite: state_d = last_word ? StChk : StData;
      StChk:   if (accept) state_d = (bus.byte_data == chk_q) ? StDone : StIdle;
`else
      StWrite: state_d = last_word ? StDone : StData;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_stall_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d == StLenLo) || (state_d == StLenHi) ||
                      (state_d == StData)  || (state_d == StChk);
      wr_en_q      <= (state_d == StWrite);
      cpu_stall_q  <= (state_d != StIdle);
      done_q       <= (state_d == StDone);
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            error_q <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end
        end
        StLenLo: if (accept) len_q[7:0] <= bus.byte_data;
        StLenHi: begin
          if (accept) begin
            len_q[15:8] <= bus.byte_data;
            if (len_bad) error_q <= 1'b1;
          end
        end
        StData: begin
          if (accept) begin
            word_q <= word_next;
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q  <= chk_q ^ bus.byte_data;
`endif
            if (lane_q == 2'd3) begin
              wr_addr_q <= idx_q;
              wr_data_q <= word_next;
            end
          end
        end
        StWrite: if (!last_word) idx_q <= idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: if (accept && bus.byte_data != chk_q) error_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = 32'(wr_addr_q);
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_stall  = cpu_stall_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load images, scoreboard of expected writes,
// plus hand-written reset-mid-load and last-word timing sequences.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;

  imem_loader_if bus();

  imem_loader #(
    .DEPTH      (1024),
    .ADDR_WIDTH (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] hdr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          start_mid;
    bit          bad_chk;
    bit          timed;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every wr_en must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst) begin
      if (bus.done) done_cnt++;
      if (bus.wr_en) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203) ^ v.w0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse_start);
    int t;
    t = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      bus.start      = pulse_start;
      @(posedge clk); #1;
      bus.start      = 1'b0;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_ready stayed 0, expected 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_stall", 32'(bus.cpu_stall), 32'd1);
    check("start_ready", 32'(bus.byte_ready), 32'd1);
    check("start_clr_err", 32'(bus.error), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(bus.wr_en), 32'd0);
    check({tag, "_wr_addr"},    bus.wr_addr, 32'd0);
    check({tag, "_wr_data"},    bus.wr_data, 32'd0);
    check({tag, "_cpu_stall"},  32'(bus.cpu_stall), 32'd0);
    check({tag, "_done"},       32'(bus.done), 32'd0);
    check({tag, "_error"},      32'(bus.error), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          t;
    int          d0;
    int          wc0;
    bit          hdr_bad;
    bit          exp_err;
    logic [7:0]  x;
    logic [31:0] w;
    n       = int'(v.hdr);
    hdr_bad = (n == 0) || (n > 1024);
    exp_err = hdr_bad || (ChkEn && v.bad_chk);
    d0      = done_cnt;
    wc0     = wr_cnt;
    x       = 8'h00;
    do_start();
    send_byte(v.hdr[7:0], 1'b0, 1'b0);
    send_byte(v.hdr[15:8], 1'b0, 1'b0);
    if (!hdr_bad) begin
      for (int i = 0; i < n; i++) begin
        w = word_of(v, i);
        sb.push_back({32'(i), w});
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8], v.gap, v.start_mid && i == 1 && b == 0);
          x = x ^ w[8*b +: 8];
        end
      end
      if (v.timed) begin
        check("last_wr_en", 32'(bus.wr_en), 32'd1);
        check("last_ready_low", 32'(bus.byte_ready), 32'd0);
      end
      if (ChkEn) send_byte(v.bad_chk ? (x ^ 8'h01) : x, 1'b0, 1'b0);
      else begin
        @(posedge clk); #1;
      end
      if (v.timed) begin
        check("done_pulse", 32'(bus.done), 32'(!exp_err));
        @(posedge clk); #1;
        check("stall_release", 32'(bus.cpu_stall), 32'd0);
      end
    end
    t = 0;
    while (bus.cpu_stall && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    check("stall_end", 32'(bus.cpu_stall), 32'd0);
    check("error", 32'(bus.error), 32'(exp_err));
    check("done_count", 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
    check("write_count", 32'(wr_cnt - wc0), hdr_bad ? 32'd0 : 32'(n));
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    vecs[0] = '{16'h0002, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h0401, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0002, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h0003, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0400, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0001, 32'h8000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Reset in the middle of the second word: first word stays written, partial word is dropped.
    do_start();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    w = 32'h0000_0013;
    sb.push_back({32'd0, w});
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0, 1'b0);
    send_byte(8'h93, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    check("mid_stall", 32'(bus.cpu_stall), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("rst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.byte_ready), 32'd0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
